// File: rtl/smem_rsp_collector_pkg.sv
// Shared sizes and entry-state type for the shared-memory response collector.
// Optional perf counters are enabled with SMEM_RSP_COLLECTOR_PERF_EN.
package smem_rsp_collector_pkg;

    localparam int NUM_REQS         = 4;
    localparam int WORD_SIZE        = 4;
    localparam int DW               = 8 * WORD_SIZE;
    localparam int CORE_TAG_WIDTH   = 10;
    localparam int CORE_TAG_ID_BITS = 4;
    localparam int NUM_ENTRIES      = 2 ** CORE_TAG_ID_BITS;
    localparam int PERF_CTR_BITS    = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        DONE = 2'd2
    } entry_state_e;

endpackage

// File: rtl/smem_rsp_collector_if.sv
// Response bus: valid/ready handshake carrying a lane mask, lane data and tag.
// Used both for the partial shared-memory beats and the merged output.
interface smem_rsp_collector_if;
    import smem_rsp_collector_pkg::*;

    logic                      valid;
    logic                      ready;
    logic [NUM_REQS-1:0]       tmask;
    logic [NUM_REQS*DW-1:0]    data;
    logic [CORE_TAG_WIDTH-1:0] tag;

    modport master (
        output valid,
        output tmask,
        output data,
        output tag,
        input  ready
    );

    modport slave (
        input  valid,
        input  tmask,
        input  data,
        input  tag,
        output ready
    );

endinterface

// File: rtl/smem_done_arbiter.sv
// Fixed-priority pick of the lowest-index DONE entry.
// Isolates the lowest set bit, then encodes it as an index.
module smem_done_arbiter
    import smem_rsp_collector_pkg::*;
(
    input  logic [NUM_ENTRIES-1:0]      done,
    output logic                        valid,
    output logic [CORE_TAG_ID_BITS-1:0] idx
);

    logic [NUM_ENTRIES-1:0] onehot;

    assign onehot = done & (~done + NUM_ENTRIES'(1));
    assign valid  = |done;

    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (onehot[i]) begin
                idx = idx | CORE_TAG_ID_BITS'(i);
            end
        end
    end

endmodule

// File: rtl/smem_rsp_collector.sv
// Merges multi-beat shared-memory read responses into one response per tag.
// SMEM_RSP_COLLECTOR_PERF_EN adds stall and peak-occupancy counters.
module smem_rsp_collector
    import smem_rsp_collector_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        alloc_valid,
    input  logic [CORE_TAG_WIDTH-1:0]   alloc_tag,
    input  logic [NUM_REQS-1:0]         alloc_mask,
    output logic                        alloc_ready,
    smem_rsp_collector_if.slave         smem_rsp,
    smem_rsp_collector_if.master        out_rsp
`ifdef SMEM_RSP_COLLECTOR_PERF_EN
    ,
    output logic [PERF_CTR_BITS-1:0]    perf_stalls,
    output logic [CORE_TAG_ID_BITS:0]   perf_max_busy
`endif
);

    entry_state_e              state_q   [NUM_ENTRIES];
    entry_state_e              state_d   [NUM_ENTRIES];
    logic [NUM_REQS-1:0]       pending_q [NUM_ENTRIES];
    logic [NUM_REQS-1:0]       pending_d [NUM_ENTRIES];
    logic [NUM_REQS-1:0]       mask_q    [NUM_ENTRIES];
    logic [NUM_REQS-1:0]       mask_d    [NUM_ENTRIES];
    logic [CORE_TAG_WIDTH-1:0] tag_q     [NUM_ENTRIES];
    logic [CORE_TAG_WIDTH-1:0] tag_d     [NUM_ENTRIES];
    logic [NUM_REQS*DW-1:0]    data_q    [NUM_ENTRIES];
    logic [NUM_REQS*DW-1:0]    data_d    [NUM_ENTRIES];

    logic [CORE_TAG_ID_BITS-1:0] alloc_idx;
    logic [CORE_TAG_ID_BITS-1:0] rsp_idx;
    logic [CORE_TAG_ID_BITS-1:0] sel_idx;
    logic [NUM_ENTRIES-1:0]      done_vec;
    logic                        sel_valid;
    logic                        alloc_fire;
    logic                        rsp_fire;
    logic                        load;

    logic                      ov_q;
    logic [NUM_REQS-1:0]       otmask_q;
    logic [NUM_REQS*DW-1:0]    odata_q;
    logic [CORE_TAG_WIDTH-1:0] otag_q;

    logic unused_rsp_tag_hi;

    assign alloc_idx  = alloc_tag[CORE_TAG_ID_BITS-1:0];
    assign rsp_idx    = smem_rsp.tag[CORE_TAG_ID_BITS-1:0];
    assign unused_rsp_tag_hi = ^smem_rsp.tag[CORE_TAG_WIDTH-1:CORE_TAG_ID_BITS];

    assign alloc_ready = (state_q[alloc_idx] == IDLE) || (alloc_mask == '0);
    assign alloc_fire  = alloc_valid && alloc_ready && (alloc_mask != '0);
    assign rsp_fire    = smem_rsp.valid;
    assign smem_rsp.ready = 1'b1;

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            done_vec[i] = (state_q[i] == DONE);
        end
    end

    smem_done_arbiter u_arb (
        .done  (done_vec),
        .valid (sel_valid),
        .idx   (sel_idx)
    );

    assign load = sel_valid && (!ov_q || out_rsp.ready);

    // Load, alloc and rsp touch disjoint entries (DONE, IDLE, PEND).
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        mask_d    = mask_q;
        tag_d     = tag_q;
        data_d    = data_q;
        if (load) begin
            state_d[sel_idx] = IDLE;
        end
        if (alloc_fire) begin
            state_d[alloc_idx]   = PEND;
            pending_d[alloc_idx] = alloc_mask;
            mask_d[alloc_idx]    = alloc_mask;
            tag_d[alloc_idx]     = alloc_tag;
            data_d[alloc_idx]    = '0;
        end
        if (rsp_fire) begin
            for (int l = 0; l < NUM_REQS; l++) begin
                if (smem_rsp.tmask[l]) begin
                    data_d[rsp_idx][l*DW +: DW] = smem_rsp.data[l*DW +: DW];
                end
            end
            pending_d[rsp_idx] = pending_q[rsp_idx] & ~smem_rsp.tmask;
            if ((pending_q[rsp_idx] & ~smem_rsp.tmask) == '0) begin
                state_d[rsp_idx] = DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                state_q[i]   <= IDLE;
                pending_q[i] <= '0;
                mask_q[i]    <= '0;
                tag_q[i]     <= '0;
                data_q[i]    <= '0;
            end
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            tag_q     <= tag_d;
            data_q    <= data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ov_q     <= 1'b0;
            otmask_q <= '0;
            odata_q  <= '0;
            otag_q   <= '0;
        end else if (load) begin
            ov_q     <= 1'b1;
            otmask_q <= mask_q[sel_idx];
            odata_q  <= data_q[sel_idx];
            otag_q   <= tag_q[sel_idx];
        end else if (out_rsp.ready) begin
            ov_q <= 1'b0;
        end
    end

    assign out_rsp.valid = ov_q;
    assign out_rsp.tmask = otmask_q;
    assign out_rsp.data  = odata_q;
    assign out_rsp.tag   = otag_q;

`ifdef SMEM_RSP_COLLECTOR_PERF_EN
    logic [CORE_TAG_ID_BITS:0] busy_cnt;

    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            busy_cnt = busy_cnt
                     + {{CORE_TAG_ID_BITS{1'b0}}, state_q[i] != IDLE};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stalls   <= '0;
            perf_max_busy <= '0;
        end else begin
            if (ov_q && !out_rsp.ready) begin
                perf_stalls <= perf_stalls + 1'b1;
            end
            if (busy_cnt > perf_max_busy) begin
                perf_max_busy <= busy_cnt;
            end
        end
    end
`endif

    logic                rsp_v_a;
    logic [NUM_REQS-1:0] rsp_m_a;

    assign rsp_v_a = smem_rsp.valid;
    assign rsp_m_a = smem_rsp.tmask;

    a_rsp_pend: assert property (@(posedge clk) disable iff (reset)
        rsp_v_a |-> state_q[rsp_idx] == PEND);
    a_rsp_lanes: assert property (@(posedge clk) disable iff (reset)
        rsp_v_a |-> (rsp_m_a & ~pending_q[rsp_idx]) == '0);
    a_rsp_mask: assert property (@(posedge clk) disable iff (reset)
        rsp_v_a |-> rsp_m_a != '0);

endmodule

// File: tb/tb_smem_rsp_collector.sv
// Directed bench for smem_rsp_collector with a per-tag behavioural model.
// Define SMEM_RSP_COLLECTOR_PERF_EN to also check the perf counters.
module tb_smem_rsp_collector;
    import smem_rsp_collector_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       alloc_valid = 1'b0;
    logic [9:0] alloc_tag = '0;
    logic [3:0] alloc_mask = '0;
    logic       alloc_ready;

    smem_rsp_collector_if rsp_if ();
    smem_rsp_collector_if out_if ();

`ifdef SMEM_RSP_COLLECTOR_PERF_EN
    logic [PERF_CTR_BITS-1:0]  perf_stalls;
    logic [CORE_TAG_ID_BITS:0] perf_max_busy;
`endif

    smem_rsp_collector dut (
        .clk         (clk),
        .reset       (reset),
        .alloc_valid (alloc_valid),
        .alloc_tag   (alloc_tag),
        .alloc_mask  (alloc_mask),
        .alloc_ready (alloc_ready),
        .smem_rsp    (rsp_if),
        .out_rsp     (out_if)
`ifdef SMEM_RSP_COLLECTOR_PERF_EN
        ,
        .perf_stalls   (perf_stalls),
        .perf_max_busy (perf_max_busy)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit started = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: 0 = free, 1 = waiting for lanes, 2 = complete
    int           m_st   [16];
    logic [3:0]   m_pend [16];
    logic [3:0]   m_msk  [16];
    logic [9:0]   m_tg   [16];
    logic [127:0] m_dat  [16];
    logic         mo_valid;
    logic [3:0]   mo_tmask;
    logic [127:0] mo_data;
    logic [9:0]   mo_tag;
    int           m_stalls;
    int           m_maxb;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                m_st[i] = 0; m_pend[i] = 0; m_msk[i] = 0;
                m_tg[i] = 0; m_dat[i] = 0;
            end
            mo_valid = 0; mo_tmask = 0; mo_data = 0; mo_tag = 0;
            m_stalls = 0; m_maxb = 0;
        end else begin
            int nb, ld, ai, ri;
            bit a_ok;
            nb = 0;
            for (int i = 0; i < 16; i++) if (m_st[i] != 0) nb++;
            if (nb > m_maxb) m_maxb = nb;
            if (mo_valid && !out_if.ready) m_stalls++;
            ai = int'(alloc_tag[3:0]);
            a_ok = (m_st[ai] == 0);
            ld = -1;
            if (!mo_valid || out_if.ready)
                for (int i = 15; i >= 0; i--) if (m_st[i] == 2) ld = i;
            if (ld >= 0) begin
                mo_valid = 1; mo_tmask = m_msk[ld];
                mo_data = m_dat[ld]; mo_tag = m_tg[ld];
                m_st[ld] = 0;
            end else if (out_if.ready) begin
                mo_valid = 0;
            end
            if (alloc_valid && alloc_mask != 0 && a_ok) begin
                m_st[ai] = 1; m_pend[ai] = alloc_mask; m_msk[ai] = alloc_mask;
                m_tg[ai] = alloc_tag; m_dat[ai] = 0;
            end
            if (rsp_if.valid) begin
                ri = int'(rsp_if.tag[3:0]);
                for (int l = 0; l < 4; l++)
                    if (rsp_if.tmask[l])
                        m_dat[ri][l*32 +: 32] = rsp_if.data[l*32 +: 32];
                m_pend[ri] = m_pend[ri] & ~rsp_if.tmask;
                if (m_pend[ri] == 0) m_st[ri] = 2;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_out_valid", out_if.valid, mo_valid);
            if (mo_valid) begin
                chk("m_out_tag", out_if.tag, mo_tag);
                chk("m_out_tmask", out_if.tmask, mo_tmask);
                chk("m_out_data", out_if.data, mo_data);
            end
            chk("m_alloc_ready", alloc_ready,
                (m_st[alloc_tag[3:0]] == 0) || (alloc_mask == 0));
`ifdef SMEM_RSP_COLLECTOR_PERF_EN
            chk("m_perf_stalls", perf_stalls, m_stalls);
            chk("m_perf_max_busy", perf_max_busy, m_maxb);
`endif
        end
    end

    int   cyc = 0;
    int   hs_cnt = 0;
    logic [9:0] hs_tag [$];
    int   hs_cyc [$];

    always @(posedge clk) begin
        cyc++;
        if (!reset && out_if.valid && out_if.ready) begin
            hs_cnt++;
            hs_tag.push_back(out_if.tag);
            hs_cyc.push_back(cyc);
        end
    end

    task automatic do_alloc(input logic [9:0] t, input logic [3:0] m);
        alloc_valid = 1; alloc_tag = t; alloc_mask = m;
        @(posedge clk); #1;
        alloc_valid = 0;
    endtask

    task automatic beat(input logic [9:0] t, input logic [3:0] m,
                        input logic [127:0] d);
        rsp_if.valid = 1; rsp_if.tag = t; rsp_if.tmask = m; rsp_if.data = d;
        @(posedge clk); #1;
        rsp_if.valid = 0;
    endtask

    initial begin
        int h0, n;
        rsp_if.valid = 0; rsp_if.tmask = 0; rsp_if.data = 0; rsp_if.tag = 0;
        out_if.ready = 1;
        repeat (2) @(posedge clk);
        #1; reset = 0; started = 1;

        chk("rst_out_valid", out_if.valid, 0);
        chk("rst_out_tag", out_if.tag, 0);
        chk("rst_out_data", out_if.data, 0);
        chk("rst_alloc_ready", alloc_ready, 1);

        // 1: single full beat
        do_alloc(10'h005, 4'hF);
        beat(10'h005, 4'hF, {32'hDDDD0004, 32'hCCCC0003,
                             32'hBBBB0002, 32'hAAAA0001});
        chk("t1_not_yet", out_if.valid, 0);
        @(posedge clk); #1;
        chk("t1_valid", out_if.valid, 1);
        chk("t1_tag", out_if.tag, 10'h005);
        chk("t1_tmask", out_if.tmask, 4'hF);
        chk("t1_data", out_if.data, {32'hDDDD0004, 32'hCCCC0003,
                                     32'hBBBB0002, 32'hAAAA0001});
        @(posedge clk); #1;

        // 2: two partial beats
        h0 = hs_cnt;
        do_alloc(10'h003, 4'b1011);
        beat(10'h003, 4'b0001, {96'h0, 32'h11111111});
        beat(10'h003, 4'b1010, {32'h44444444, 32'h33333333,
                                32'h22222222, 32'h0});
        chk("t2_not_yet", out_if.valid, 0);
        @(posedge clk); #1;
        chk("t2_tag", out_if.tag, 10'h003);
        chk("t2_tmask", out_if.tmask, 4'b1011);
        chk("t2_data", out_if.data, {32'h44444444, 32'h0,
                                     32'h22222222, 32'h11111111});
        repeat (4) @(posedge clk); #1;
        chk("t2_once", hs_cnt - h0, 1);

        // 3: backpressure with two completed tags
        out_if.ready = 0;
        do_alloc(10'h007, 4'b0001);
        do_alloc(10'h002, 4'b0001);
        beat(10'h002, 4'b0001, {96'h0, 32'h00000002});
        beat(10'h007, 4'b0001, {96'h0, 32'h00000007});
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", out_if.valid, 1);
            chk("t3_hold_tag", out_if.tag, 10'h002);
            @(posedge clk); #1;
        end
        out_if.ready = 1;
        @(posedge clk); #1;
        chk("t3_second_tag", out_if.tag, 10'h007);
        @(posedge clk); #1;
        chk("t3_drained", out_if.valid, 0);
        n = hs_tag.size();
        chk("t3_first", hs_tag[n-2], 10'h002);
        chk("t3_next", hs_tag[n-1], 10'h007);
        chk("t3_b2b", hs_cyc[n-1] - hs_cyc[n-2], 1);

        // 4: alloc blocked while entry busy
        do_alloc(10'h014, 4'b0011);
        alloc_valid = 1; alloc_tag = 10'h034; alloc_mask = 4'b0001;
        #1;
        chk("t4_blocked", alloc_ready, 0);
        beat(10'h014, 4'b0011, {64'h0, 32'h0000B004, 32'h0000A004});
        chk("t4_blocked_done", alloc_ready, 0);
        @(posedge clk); #1;
        chk("t4_free", alloc_ready, 1);
        chk("t4_out_tag", out_if.tag, 10'h014);
        @(posedge clk); #1;
        alloc_valid = 0;
        chk("t4_taken", alloc_ready, 0);
        beat(10'h034, 4'b0001, {96'h0, 32'h00C0FFEE});
        repeat (2) @(posedge clk); #1;
        chk("t4_new_out", hs_tag[hs_tag.size()-1], 10'h034);

        // 5: write-only request
        h0 = hs_cnt;
        alloc_valid = 1; alloc_tag = 10'h009; alloc_mask = 4'b0000;
        #1;
        chk("t5_ready", alloc_ready, 1);
        @(posedge clk); #1;
        alloc_valid = 0; alloc_mask = 4'hF;
        chk("t5_still_idle", alloc_ready, 1);
        repeat (5) @(posedge clk); #1;
        chk("t5_no_out", hs_cnt - h0, 0);

        // 6: reset mid-operation
        do_alloc(10'h001, 4'hF);
        do_alloc(10'h00A, 4'hF);
        do_alloc(10'h00F, 4'hF);
        out_if.ready = 0;
        do_alloc(10'h00C, 4'b0001);
        beat(10'h00C, 4'b0001, {96'h0, 32'h0000000C});
        @(posedge clk); #1;
        chk("t6_pre_valid", out_if.valid, 1);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        chk("t6_out_cleared", out_if.valid, 0);
`ifdef SMEM_RSP_COLLECTOR_PERF_EN
        chk("t6_perf_stalls", perf_stalls, 0);
        chk("t6_perf_max_busy", perf_max_busy, 0);
`endif
        alloc_mask = 4'hF;
        alloc_tag = 10'h001; #1;
        chk("t6_ready_1", alloc_ready, 1);
        alloc_tag = 10'h00A; #1;
        chk("t6_ready_a", alloc_ready, 1);
        alloc_tag = 10'h00F; #1;
        chk("t6_ready_f", alloc_ready, 1);
        out_if.ready = 1;
        repeat (3) @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
